// File: rtl/rvc_fetch_aligner.sv
// rvc_fetch_aligner: fetches 32-bit words into a halfword queue and issues realigned 16/32-bit instructions.
// Latency: fetched halfwords are issuable the cycle after mem_ack (same cycle when RVC_FETCH_BYPASS_EN is defined).
// Backpressure: outputs hold while out_valid & ~out_ready; fetch pauses until the queue has room for a whole word.
module rvc_fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_is_c,
  output logic [31:0] out_pc
);

  localparam int          PW     = $clog2(QDEPTH);
  localparam int          CW     = $clog2(QDEPTH + 1);
  localparam logic [PW:0] QD_PTR = (PW+1)'(QDEPTH);
  localparam logic [CW:0] QD_CNT = (CW+1)'(QDEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_DISCARD = 2'd2
  } state_e;

  // Pointer advance by 0..2 with wrap at QDEPTH (QDEPTH need not be a power of two).
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
    logic [PW:0] s;
    s = {1'b0, p} + (PW+1)'(n);
    if (s >= QD_PTR) s = s - QD_PTR;
    return s[PW-1:0];
  endfunction

  // Fetch side state
  state_e      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] tgt_q, tgt_d;
  logic        skip_q, skip_d;

  // Queue / issue state
  logic [15:0]   qmem_q [QDEPTH];
  logic [15:0]   qmem_d [QDEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pc_q, pc_d;

  // Incoming word, unpacked from memory byte order into halfwords
  logic [15:0] mem_hw0, mem_hw1;
  logic [15:0] in_hw0, in_hw1;
  logic [1:0]  in_n;
  logic        ack_live;
  logic [31:0] redirect_tgt;
  logic [CW-1:0] count_eff;
  logic        fetch_room;

  // Issue view
  logic [15:0] head0, head1;
  logic [15:0] view0, view1;
  logic [CW:0] avail;
  logic        head_is_c;
  logic [1:0]  need;
  logic        issue_vld;
  logic [1:0]  pop_n;
  logic [1:0]  from_q, from_in, push_n;

  assign mem_hw0      = {mem_rdata[7:0],   mem_rdata[15:8]};
  assign mem_hw1      = {mem_rdata[23:16], mem_rdata[31:24]};
  assign redirect_tgt = {redirect_pc[31:2], 2'b00};

  // Data accepted into the aligner only from a live request not being flushed this cycle.
  assign ack_live = (state_q == S_REQ) && mem_ack && !redirect;
  assign in_hw0   = skip_q ? mem_hw1 : mem_hw0;
  assign in_hw1   = mem_hw1;
  assign in_n     = ack_live ? (skip_q ? 2'd1 : 2'd2) : 2'd0;

  // A redirect empties the queue, so the room check sees it as empty in that cycle.
  assign count_eff  = redirect ? '0 : count_q;
  assign fetch_room = ({1'b0, count_eff} + (CW+1)'(2)) <= QD_CNT;

  // Fetch FSM next state: one request outstanding, address held until acked.
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    tgt_d      = tgt_q;
    skip_d     = skip_q;
    case (state_q)
      S_IDLE: begin
        if (redirect) begin
          mem_addr_d = redirect_tgt;
          skip_d     = redirect_pc[1];
        end
        if (fetch_room) state_d = S_REQ;
      end
      S_REQ: begin
        if (mem_ack) begin
          state_d = S_IDLE;
          if (redirect) begin
            mem_addr_d = redirect_tgt;
            skip_d     = redirect_pc[1];
          end else begin
            mem_addr_d = mem_addr_q + 32'd4;
            skip_d     = 1'b0;
          end
        end else if (redirect) begin
          // Request cannot be retracted; remember the new target and swallow the old data.
          state_d = S_DISCARD;
          tgt_d   = redirect_tgt;
          skip_d  = redirect_pc[1];
        end
      end
      S_DISCARD: begin
        if (redirect) begin
          tgt_d  = redirect_tgt;
          skip_d = redirect_pc[1];
        end
        if (mem_ack) begin
          state_d    = S_IDLE;
          mem_addr_d = redirect ? redirect_tgt : tgt_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
    mem_req_d = (state_d != S_IDLE);
  end

  // Fetch FSM registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= {RESET_PC[31:2], 2'b00};
      tgt_q      <= {RESET_PC[31:2], 2'b00};
      skip_q     <= RESET_PC[1];
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      tgt_q      <= tgt_d;
      skip_q     <= skip_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

  // Issue view: queue head, optionally extended with the halfwords arriving this cycle.
  always_comb begin
    head0 = qmem_q[rd_ptr_q];
    head1 = qmem_q[ptr_add(rd_ptr_q, 2'd1)];
`ifdef RVC_FETCH_BYPASS_EN
    view0 = (count_q != '0) ? head0 : in_hw0;
    view1 = (count_q >= CW'(2)) ? head1 : ((count_q == CW'(1)) ? in_hw0 : in_hw1);
    avail = {1'b0, count_q} + (CW+1)'(in_n);
`else
    view0 = head0;
    view1 = head1;
    avail = {1'b0, count_q};
`endif
    head_is_c = (view0[1:0] != 2'b11);
    need      = head_is_c ? 2'd1 : 2'd2;
    issue_vld = (avail >= (CW+1)'(need)) && !redirect;
    pop_n     = (issue_vld && out_ready) ? need : 2'd0;
  end

  assign out_valid = issue_vld;
  assign out_is_c  = issue_vld & head_is_c;
  assign out_instr = !issue_vld ? 32'd0 : (head_is_c ? {16'd0, view0} : {view1, view0});
  assign out_pc    = pc_q;

  // Queue update: pops drain stored halfwords first, then any bypassed incoming ones; leftovers are written.
  always_comb begin
    qmem_d = qmem_q;
    if (count_q == '0)            from_q = 2'd0;
    else if (count_q == CW'(1))   from_q = (pop_n != 2'd0) ? 2'd1 : 2'd0;
    else                          from_q = pop_n;
    from_in = pop_n - from_q;
    push_n  = in_n - from_in;
    if (push_n == 2'd2) begin
      qmem_d[wr_ptr_q]                  = in_hw0;
      qmem_d[ptr_add(wr_ptr_q, 2'd1)]   = in_hw1;
    end else if (push_n == 2'd1) begin
      qmem_d[wr_ptr_q] = (from_in == 2'd1) ? in_hw1 : in_hw0;
    end
    rd_ptr_d = ptr_add(rd_ptr_q, from_q);
    wr_ptr_d = ptr_add(wr_ptr_q, push_n);
    count_d  = count_q - CW'(from_q) + CW'(push_n);
    pc_d     = pc_q + {29'd0, pop_n, 1'b0};
    if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      pc_d     = redirect_pc;
    end
  end

  // Queue and PC registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) qmem_q[i] <= 16'd0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      pc_q     <= RESET_PC;
    end else begin
      for (int i = 0; i < QDEPTH; i++) qmem_q[i] <= qmem_d[i];
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      pc_q     <= pc_d;
    end
  end

endmodule

// File: tb/tb_rvc_fetch_aligner.sv
// tb_rvc_fetch_aligner: directed bench for the RVC fetch aligner.
// Expected instruction stream is a hand-written table; corner cases are hand sequences.
// Memory model acks a held request after a programmable number of cycles.
module tb_rvc_fetch_aligner;
  localparam int QD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_is_c;
  logic [31:0] out_pc;

  always #5 clk = ~clk;

  rvc_fetch_aligner #(.RESET_PC(32'h0000_0000), .QDEPTH(QD)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_is_c(out_is_c), .out_pc(out_pc)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        is_c;
  } exp_t;

  localparam int NEXP = 22;
  exp_t        exp_tab [NEXP];
  int          errors = 0;
  int          checks = 0;
  int          xfer_n = 0;
  int          ack_lat = 1;
  int          max_cnt = 0;
  logic [31:0] mem [0:127];
  logic [31:0] ack_addrs [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Stores halfword h (normal bit order) at byte address a in memory byte order.
  task automatic put_hw(input logic [31:0] a, input logic [15:0] h);
    logic [31:0] w;
    w = mem[a[8:2]];
    if (a[1]) w[31:16] = {h[7:0], h[15:8]};
    else      w[15:0]  = {h[7:0], h[15:8]};
    mem[a[8:2]] = w;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Memory: acks a held request after ack_lat waiting cycles; reset with the DUT.
  initial begin
    int cnt;
    cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n || !mem_req) begin
        mem_ack = 1'b0;
        cnt = 0;
      end else if (cnt >= ack_lat) begin
        mem_ack = 1'b1;
        mem_rdata = mem[mem_addr[8:2]];
        cnt = 0;
      end else begin
        mem_ack = 1'b0;
        cnt++;
      end
    end
  end

  // Transfer scoreboard and queue occupancy watch, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (int'(dut.count_q) > max_cnt) max_cnt = int'(dut.count_q);
      if (mem_req && mem_ack) ack_addrs.push_back(mem_addr);
      if (out_valid && out_ready) begin
        if (xfer_n < NEXP) begin
          check($sformatf("xfer%0d_pc", xfer_n), out_pc, exp_tab[xfer_n].pc);
          check($sformatf("xfer%0d_instr", xfer_n), out_instr, exp_tab[xfer_n].instr);
          check($sformatf("xfer%0d_is_c", xfer_n), {31'd0, out_is_c}, {31'd0, exp_tab[xfer_n].is_c});
        end else begin
          check("extra_xfer_pc", out_pc, 32'hFFFF_FFFF);
        end
        xfer_n++;
      end
    end
  end

  task automatic run_until(input int target, input int budget);
    int b;
    b = budget;
    out_ready = 1'b1;
    while (xfer_n < target && b > 0) begin
      step();
      b--;
    end
    out_ready = 1'b0;
    check($sformatf("drain_to_%0d", target), xfer_n, target);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, xfer_n=%0d", xfer_n);
    $fatal(1);
  end

  initial begin
    int  b;
    int  xfer0;
    logic byp_exp;

    exp_tab[0]  = '{32'h000, 32'h0000_4501, 1'b1};
    exp_tab[1]  = '{32'h002, 32'h0000_0013, 1'b0};
    exp_tab[2]  = '{32'h006, 32'h0000_4505, 1'b1};
    exp_tab[3]  = '{32'h008, 32'h0010_0093, 1'b0};
    exp_tab[4]  = '{32'h00C, 32'h0000_8082, 1'b1};
    exp_tab[5]  = '{32'h00E, 32'h0000_0001, 1'b1};
    exp_tab[6]  = '{32'h010, 32'h0020_0113, 1'b0};
    exp_tab[7]  = '{32'h014, 32'h0000_0001, 1'b1};
    exp_tab[8]  = '{32'h016, 32'h0030_0193, 1'b0};
    exp_tab[9]  = '{32'h01A, 32'h0000_4509, 1'b1};
    exp_tab[10] = '{32'h01C, 32'h0000_450D, 1'b1};
    exp_tab[11] = '{32'h01E, 32'h0000_4511, 1'b1};
    exp_tab[12] = '{32'h020, 32'h0040_0213, 1'b0};
    exp_tab[13] = '{32'h024, 32'h0000_4515, 1'b1};
    exp_tab[14] = '{32'h026, 32'h0000_4519, 1'b1};
    exp_tab[15] = '{32'h028, 32'h0000_451D, 1'b1};
    exp_tab[16] = '{32'h106, 32'h0000_4521, 1'b1};
    exp_tab[17] = '{32'h108, 32'h0050_0293, 1'b0};
    exp_tab[18] = '{32'h10C, 32'h0000_4525, 1'b1};
    exp_tab[19] = '{32'h10E, 32'h0000_4529, 1'b1};
    exp_tab[20] = '{32'h1C0, 32'h0000_4531, 1'b1};
    exp_tab[21] = '{32'h1C2, 32'h0060_0313, 1'b0};

    // Background: compressed NOPs everywhere.
    for (int i = 0; i < 128; i++) mem[i] = 32'h0100_0100;
    put_hw(32'h000, 16'h4501); put_hw(32'h002, 16'h0013); put_hw(32'h004, 16'h0000);
    put_hw(32'h006, 16'h4505); put_hw(32'h008, 16'h0093); put_hw(32'h00A, 16'h0010);
    put_hw(32'h00C, 16'h8082); put_hw(32'h00E, 16'h0001); put_hw(32'h010, 16'h0113);
    put_hw(32'h012, 16'h0020); put_hw(32'h014, 16'h0001); put_hw(32'h016, 16'h0193);
    put_hw(32'h018, 16'h0030); put_hw(32'h01A, 16'h4509); put_hw(32'h01C, 16'h450D);
    put_hw(32'h01E, 16'h4511); put_hw(32'h020, 16'h0213); put_hw(32'h022, 16'h0040);
    put_hw(32'h024, 16'h4515); put_hw(32'h026, 16'h4519); put_hw(32'h028, 16'h451D);
    put_hw(32'h104, 16'h0073); put_hw(32'h106, 16'h4521); put_hw(32'h108, 16'h0293);
    put_hw(32'h10A, 16'h0050); put_hw(32'h10C, 16'h4525); put_hw(32'h10E, 16'h4529);
    put_hw(32'h180, 16'h4535); put_hw(32'h182, 16'h0073); put_hw(32'h184, 16'h0073);
    put_hw(32'h186, 16'h0073); put_hw(32'h1C0, 16'h4531); put_hw(32'h1C2, 16'h0313);
    put_hw(32'h1C4, 16'h0060);

    rst_n = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'd0;
    out_ready = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_mem_req",   {31'd0, mem_req},   32'd0);
    check("rst_mem_addr",  mem_addr,           32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_instr", out_instr,          32'd0);
    check("rst_out_is_c",  {31'd0, out_is_c},  32'd0);
    check("rst_out_pc",    out_pc,             32'd0);

    @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    @(negedge clk);
    check("first_req",      {31'd0, mem_req}, 32'd1);
    check("first_req_addr", mem_addr,         32'd0);

    // Main stream: mixed RVC / 32-bit, including straddles at PC 2 and 0x16.
    run_until(12, 400);
    for (int i = 0; i < 3; i++)
      check($sformatf("ack_addr%0d", i),
            (ack_addrs.size() > i) ? ack_addrs[i] : 32'hFFFF_FFFF, 32'(4 * i));

    // Backpressure: queue fills, fetch stops, head holds.
    repeat (12) step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_mem_req",   {31'd0, mem_req},   32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_out_pc",    out_pc,             32'h20);
      check("bp_out_instr", out_instr,          32'h0040_0213);
      step();
    end
    run_until(16, 200);

    // Redirect while a request is outstanding: old data discarded, restart at 0x104 skipping hw0.
    ack_lat = 3;
    redirect = 1'b1; redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    b = 40;
    while (!(mem_req && mem_addr == 32'h40) && b > 0) begin step(); b--; end
    check("req40_seen", {31'd0, mem_req}, 32'd1);
    check("req40_no_ack", {31'd0, mem_ack}, 32'd0);
    redirect = 1'b1; redirect_pc = 32'h106;
    @(negedge clk);
    check("redir_valid_off", {31'd0, out_valid}, 32'd0);
    step();
    redirect = 1'b0;
    @(negedge clk);
    check("discard_req_held",  {31'd0, mem_req}, 32'd1);
    check("discard_addr_held", mem_addr,         32'h40);
    check("discard_out_pc",    out_pc,           32'h106);
    check("discard_valid",     {31'd0, out_valid}, 32'd0);
    step();
    b = 40;
    while (!(mem_req && mem_addr == 32'h104) && b > 0) begin step(); b--; end
    check("restart_req",  {31'd0, mem_req}, 32'd1);
    check("restart_addr", mem_addr,         32'h104);
    ack_lat = 1;
    run_until(20, 200);

    // Fetch from empty: bypass build issues in the ack cycle.
`ifdef RVC_FETCH_BYPASS_EN
    byp_exp = 1'b1;
`else
    byp_exp = 1'b0;
`endif
    ack_lat = 3;
    redirect = 1'b1; redirect_pc = 32'h180;
    step();
    redirect = 1'b0;
    b = 40;
    while (!(mem_req && mem_ack && mem_addr == 32'h180) && b > 0) begin step(); b--; end
    check("ack180_seen", {31'd0, mem_ack}, 32'd1);
    @(negedge clk);
    check("ack_cycle_valid", {31'd0, out_valid}, {31'd0, byp_exp});
    check("ack_cycle_pc",    out_pc,             32'h180);
    step();
    @(negedge clk);
    check("post_ack_valid", {31'd0, out_valid}, 32'd1);
    check("post_ack_instr", out_instr,          32'h0000_4535);
    check("post_ack_is_c",  {31'd0, out_is_c},  32'd1);

    // Redirect coinciding with ack and a would-be transfer.
    b = 40;
    while (!(mem_req && mem_ack && mem_addr == 32'h184) && b > 0) begin step(); b--; end
    check("ack184_seen", {31'd0, mem_ack}, 32'd1);
    xfer0 = xfer_n;
    out_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h1C0;
    @(negedge clk);
    check("coinc_valid_off", {31'd0, out_valid}, 32'd0);
    step();
    out_ready = 1'b0;
    redirect = 1'b0;
    check("coinc_no_xfer", xfer_n, xfer0);
    @(negedge clk);
    check("coinc_idle", {31'd0, mem_req}, 32'd0);
    ack_lat = 1;
    b = 3;
    while (!mem_req && b > 0) begin step(); b--; end
    check("coinc_restart_req",  {31'd0, mem_req}, 32'd1);
    check("coinc_restart_addr", mem_addr,         32'h1C0);
    run_until(22, 200);

    check("max_queue_count", {31'd0, (max_cnt <= QD)}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
